// File: rtl/motor_drv_pkg.sv
// Shared encodings for the H-bridge motor driver: channel states, command codes
// and bridge leg indices.
package motor_drv_pkg;

  typedef logic [1:0] ch_state_t;

  localparam ch_state_t ST_OFF  = 2'd0;
  localparam ch_state_t ST_DEAD = 2'd1;
  localparam ch_state_t ST_RAMP = 2'd2;
  localparam ch_state_t ST_RUN  = 2'd3;

  localparam logic [1:0] CMD_COAST = 2'b00;
  localparam logic [1:0] CMD_REV   = 2'b01;
  localparam logic [1:0] CMD_FWD   = 2'b10;
  localparam logic [1:0] CMD_ILL   = 2'b11;

  localparam int LEG_FWD = 1;
  localparam int LEG_REV = 0;

  // Only the leg selected by the direction can ever be driven.
  function automatic logic [1:0] leg_drive(input logic fwd, input logic on);
    logic [1:0] legs;
    legs = 2'b00;
    if (fwd) begin
      legs[LEG_FWD] = on;
    end else begin
      legs[LEG_REV] = on;
    end
    return legs;
  endfunction

endpackage

// File: rtl/motor_hbridge_driver_if.sv
// Command/status bundle between the microbot controller (master) and the
// H-bridge driver (slave).
interface motor_hbridge_driver_if #(
  parameter int PWM_BITS = 8
);
  logic                enable;
  logic [1:0]          cmd_a;
  logic [1:0]          cmd_b;
  logic [PWM_BITS-1:0] duty_max;
  logic [1:0]          hb_a;
  logic [1:0]          hb_b;
  logic                busy;
  logic                fault;

  modport master (
    output enable, cmd_a, cmd_b, duty_max,
    input  hb_a, hb_b, busy, fault
  );

  modport slave (
    input  enable, cmd_a, cmd_b, duty_max,
    output hb_a, hb_b, busy, fault
  );
endinterface

// File: rtl/hbridge_channel.sv
// One motor channel: OFF/DEAD/RAMP/RUN state machine with dead-time, duty ramp
// and registered PWM-gated leg outputs.
module hbridge_channel
  import motor_drv_pkg::*;
#(
  parameter int PWM_BITS     = 8,
  parameter int DEADTIME_CYC = 16,
  parameter int RAMP_STEP    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                ramp_tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic [1:0]          cmd,
  input  logic [PWM_BITS-1:0] duty_max,
  output logic [1:0]          hb,
  output logic                busy,
  output logic                ill
);

  localparam int DW = (DEADTIME_CYC > 1) ? $clog2(DEADTIME_CYC) : 1;
  localparam logic [DW-1:0]     DEAD_LOAD = DW'(DEADTIME_CYC - 1);
  localparam logic [PWM_BITS:0] STEP_EXT  = (PWM_BITS + 1)'(RAMP_STEP);

  ch_state_t           state_r, state_s;
  logic                dir_fwd_r, dir_fwd_s;
  logic [DW-1:0]       dead_cnt_r, dead_cnt_s;
  logic [PWM_BITS-1:0] duty_r, duty_s;
  logic [1:0]          hb_r, hb_s;
  logic                busy_r, busy_s;
  logic [1:0]          cmd_eff_s;
  logic                want_fwd_s;
  logic                reverse_s;
  logic [PWM_BITS:0]   ramp_sum_s;

  assign ill        = (cmd == CMD_ILL);
  assign cmd_eff_s  = ill ? CMD_COAST : cmd;
  assign want_fwd_s = (cmd_eff_s == CMD_FWD);
  assign reverse_s  = (want_fwd_s != dir_fwd_r);
  // One spare bit so the ramp saturates instead of wrapping.
  assign ramp_sum_s = {1'b0, duty_r} + STEP_EXT;

  // Next-state, direction, dead-time and duty; command changes take priority.
  always_comb begin
    state_s    = state_r;
    dir_fwd_s  = dir_fwd_r;
    dead_cnt_s = dead_cnt_r;
    duty_s     = duty_r;
    if (!enable || (cmd_eff_s == CMD_COAST)) begin
      state_s = ST_OFF;
      duty_s  = '0;
    end else begin
      case (state_r)
        ST_OFF: begin
          state_s    = ST_DEAD;
          dir_fwd_s  = want_fwd_s;
          dead_cnt_s = DEAD_LOAD;
          duty_s     = '0;
        end
        ST_DEAD: begin
          if (reverse_s) begin
            dir_fwd_s  = want_fwd_s;
            dead_cnt_s = DEAD_LOAD;
          end else if (dead_cnt_r == '0) begin
            state_s = ST_RAMP;
            duty_s  = '0;
          end else begin
            dead_cnt_s = dead_cnt_r - 1'b1;
          end
        end
        ST_RAMP: begin
          if (reverse_s) begin
            state_s    = ST_DEAD;
            dir_fwd_s  = want_fwd_s;
            dead_cnt_s = DEAD_LOAD;
            duty_s     = '0;
          end else if (duty_r >= duty_max) begin
            state_s = ST_RUN;
            duty_s  = duty_max;
          end else if (ramp_tick) begin
            duty_s = (ramp_sum_s >= {1'b0, duty_max}) ? duty_max : ramp_sum_s[PWM_BITS-1:0];
          end else begin
            duty_s = duty_r;
          end
        end
        ST_RUN: begin
          if (reverse_s) begin
            state_s    = ST_DEAD;
            dir_fwd_s  = want_fwd_s;
            dead_cnt_s = DEAD_LOAD;
            duty_s     = '0;
          end else if (duty_max > duty_r) begin
            state_s = ST_RAMP;
          end else begin
            duty_s = duty_max;
          end
        end
        default: begin
          state_s = ST_OFF;
          duty_s  = '0;
        end
      endcase
    end
  end

  // Legs follow the next state so a stop or reversal drops them on the very next edge.
  always_comb begin
    if ((state_s == ST_RAMP) || (state_s == ST_RUN)) begin
      hb_s = leg_drive(dir_fwd_s, pwm_cnt < duty_s);
    end else begin
      hb_s = 2'b00;
    end
    busy_s = (state_s == ST_DEAD) || (state_s == ST_RAMP);
  end

  // Channel state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_OFF;
      dir_fwd_r  <= 1'b0;
      dead_cnt_r <= '0;
      duty_r     <= '0;
      hb_r       <= 2'b00;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      dir_fwd_r  <= dir_fwd_s;
      dead_cnt_r <= dead_cnt_s;
      duty_r     <= duty_s;
      hb_r       <= hb_s;
      busy_r     <= busy_s;
    end
  end

  assign hb   = hb_r;
  assign busy = busy_r;

endmodule

// File: rtl/motor_hbridge_driver.sv
// Two-channel H-bridge driver: shared PWM counter and ramp prescaler feeding
// one hbridge_channel per motor, plus sticky fault and busy summary.
module motor_hbridge_driver
  import motor_drv_pkg::*;
#(
  parameter int PWM_BITS     = 8,
  parameter int DEADTIME_CYC = 16,
  parameter int RAMP_DIV     = 64,
  parameter int RAMP_STEP    = 8
) (
  input logic                   clk,
  input logic                   reset,
  motor_hbridge_driver_if.slave bus
);

  localparam int PRW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PRW-1:0] PRESC_LAST = PRW'(RAMP_DIV - 1);

  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic [PRW-1:0]      presc_r;
  logic                ramp_tick_s;
  logic                fault_r;
  logic                busy_a_s, busy_b_s;
  logic                ill_a_s, ill_b_s;

  assign ramp_tick_s = (presc_r == PRESC_LAST);

  // Free-running PWM counter, ramp prescaler and sticky illegal-command flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt_r <= '0;
      presc_r   <= '0;
      fault_r   <= 1'b0;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + 1'b1;
      presc_r   <= ramp_tick_s ? '0 : presc_r + 1'b1;
      fault_r   <= fault_r | ill_a_s | ill_b_s;
    end
  end

  hbridge_channel #(
    .PWM_BITS    (PWM_BITS),
    .DEADTIME_CYC(DEADTIME_CYC),
    .RAMP_STEP   (RAMP_STEP)
  ) u_chan_a (
    .clk      (clk),
    .reset    (reset),
    .enable   (bus.enable),
    .ramp_tick(ramp_tick_s),
    .pwm_cnt  (pwm_cnt_r),
    .cmd      (bus.cmd_a),
    .duty_max (bus.duty_max),
    .hb       (bus.hb_a),
    .busy     (busy_a_s),
    .ill      (ill_a_s)
  );

  hbridge_channel #(
    .PWM_BITS    (PWM_BITS),
    .DEADTIME_CYC(DEADTIME_CYC),
    .RAMP_STEP   (RAMP_STEP)
  ) u_chan_b (
    .clk      (clk),
    .reset    (reset),
    .enable   (bus.enable),
    .ramp_tick(ramp_tick_s),
    .pwm_cnt  (pwm_cnt_r),
    .cmd      (bus.cmd_b),
    .duty_max (bus.duty_max),
    .hb       (bus.hb_b),
    .busy     (busy_b_s),
    .ill      (ill_b_s)
  );

  assign bus.busy  = busy_a_s | busy_b_s;
  assign bus.fault = fault_r;

endmodule

// File: tb/tb_motor_hbridge_driver.sv
// Scenario bench for motor_hbridge_driver: reset, start-up, reversal, illegal
// command, enable drop, duty edge cases and asynchronous reset mid-run.
module tb_motor_hbridge_driver;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  motor_hbridge_driver_if #(.PWM_BITS(8)) bus();

  motor_hbridge_driver #(
    .PWM_BITS(8), .DEADTIME_CYC(16), .RAMP_DIV(64), .RAMP_STEP(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  int exp_q[$];
  logic shoot_seen = 1'b0;

  always @(negedge clk) begin
    if (bus.hb_a == 2'b11 || bus.hb_b == 2'b11) shoot_seen = 1'b1;
  end

  // Wait (bounded) until no channel is busy; report busy length and first active-leg cycle.
  task automatic wait_run(input bit ch_b, input int budget, output int busy_len,
                          output int first_nz, output bit ok);
    logic [1:0] hb;
    ok = 1'b0; busy_len = -1; first_nz = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      hb = ch_b ? bus.hb_b : bus.hb_a;
      if (hb != 2'b00 && first_nz < 0) first_nz = c;
      if (!bus.busy) begin
        busy_len = c - 1;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic measure(input bit ch_b, input int n, output int hi_fwd, output int hi_rev);
    logic [1:0] hb;
    hi_fwd = 0; hi_rev = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      hb = ch_b ? bus.hb_b : bus.hb_a;
      hi_fwd += int'(hb[1]);
      hi_rev += int'(hb[0]);
    end
  endtask

  task automatic test_reset();
    int got, exp;
    @(negedge clk);
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: got = int'(bus.hb_a);
        1: got = int'(bus.hb_b);
        2: got = int'(bus.busy);
        default: got = int'(bus.fault);
      endcase
      exp = exp_q.pop_front();
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL reset_out%0d: got %0d expected %0d", k, got, exp);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_start();
    int got, exp, blen, fnz, hf, hr;
    bit ok;
    bus.enable = 1'b1; bus.duty_max = 8'd64; bus.cmd_a = 2'b10;
    exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1);
    exp_q.push_back(64); exp_q.push_back(0);
    wait_run(1'b0, 1500, blen, fnz, ok);
    got = int'(ok); exp = exp_q.pop_front(); compared++;
    if (got !== exp) begin mismatched++; $display("FAIL start_reach_run: got %0d expected %0d", got, exp); end
    got = int'((fnz - 1) >= 16); exp = exp_q.pop_front(); compared++;
    if (got !== exp) begin mismatched++; $display("FAIL start_deadtime: got %0d zero cycles, need >=16", fnz - 1); end
    got = int'(blen >= 460 && blen <= 535); exp = exp_q.pop_front(); compared++;
    if (got !== exp) begin mismatched++; $display("FAIL start_ramp_len: got %0d busy cycles expected 460..535", blen); end
    measure(1'b0, 256, hf, hr);
    exp = exp_q.pop_front(); compared++;
    if (hf !== exp) begin mismatched++; $display("FAIL start_fwd_high: got %0d expected %0d", hf, exp); end
    exp = exp_q.pop_front(); compared++;
    if (hr !== exp) begin mismatched++; $display("FAIL start_rev_high: got %0d expected %0d", hr, exp); end
  endtask

  task automatic test_reversal();
    int got, exp, blen, fnz, hf, hr;
    bit ok;
    bus.cmd_a = 2'b01;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1);
    exp_q.push_back(1); exp_q.push_back(64); exp_q.push_back(0);
    @(negedge clk);
    got = int'(bus.hb_a); exp = exp_q.pop_front(); compared++;
    if (got !== exp) begin mismatched++; $display("FAIL rev_legs_off: got %0d expected %0d", got, exp); end
    got = int'(bus.busy); exp = exp_q.pop_front(); compared++;
    if (got !== exp) begin mismatched++; $display("FAIL rev_busy: got %0d expected %0d", got, exp); end
    wait_run(1'b0, 1500, blen, fnz, ok);
    got = int'(ok); exp = exp_q.pop_front(); compared++;
    if (got !== exp) begin mismatched++; $display("FAIL rev_reach_run: got %0d expected %0d", got, exp); end
    got = int'(fnz >= 16); exp = exp_q.pop_front(); compared++;
    if (got !== exp) begin mismatched++; $display("FAIL rev_deadtime: got %0d zero cycles, need >=16", fnz); end
    got = int'((blen + 1) >= 460 && (blen + 1) <= 535); exp = exp_q.pop_front(); compared++;
    if (got !== exp) begin mismatched++; $display("FAIL rev_ramp_len: got %0d busy cycles expected 460..535", blen + 1); end
    measure(1'b0, 256, hf, hr);
    exp = exp_q.pop_front(); compared++;
    if (hr !== exp) begin mismatched++; $display("FAIL rev_rev_high: got %0d expected %0d", hr, exp); end
    exp = exp_q.pop_front(); compared++;
    if (hf !== exp) begin mismatched++; $display("FAIL rev_fwd_high: got %0d expected %0d", hf, exp); end
  endtask

  task automatic test_illegal();
    int got, exp, hf, hr;
    bus.cmd_b = 2'b11;
    exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(64);
    @(negedge clk);
    bus.cmd_b = 2'b00;
    got = int'(bus.fault); exp = exp_q.pop_front(); compared++;
    if (got !== exp) begin mismatched++; $display("FAIL ill_fault_set: got %0d expected %0d", got, exp); end
    got = int'(bus.busy); exp = exp_q.pop_front(); compared++;
    if (got !== exp) begin mismatched++; $display("FAIL ill_busy: got %0d expected %0d", got, exp); end
    got = int'(bus.hb_b); exp = exp_q.pop_front(); compared++;
    if (got !== exp) begin mismatched++; $display("FAIL ill_hb_b: got %0d expected %0d", got, exp); end
    repeat (20) @(negedge clk);
    got = int'(bus.fault); exp = exp_q.pop_front(); compared++;
    if (got !== exp) begin mismatched++; $display("FAIL ill_fault_sticky: got %0d expected %0d", got, exp); end
    measure(1'b0, 256, hf, hr);
    exp = exp_q.pop_front(); compared++;
    if (hr !== exp) begin mismatched++; $display("FAIL ill_a_unaffected: got %0d expected %0d", hr, exp); end
  endtask

  task automatic test_enable_drop();
    int got, exp, blen, fnz, hf, hr;
    bit ok;
    bus.cmd_b = 2'b10;
    wait_run(1'b1, 1500, blen, fnz, ok);
    exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(1);
    got = int'(ok); exp = exp_q.pop_front(); compared++;
    if (got !== exp) begin mismatched++; $display("FAIL en_both_run: got %0d expected %0d", got, exp); end
    bus.enable = 1'b0;
    @(negedge clk);
    got = int'(bus.hb_a); exp = exp_q.pop_front(); compared++;
    if (got !== exp) begin mismatched++; $display("FAIL en_hb_a: got %0d expected %0d", got, exp); end
    got = int'(bus.hb_b); exp = exp_q.pop_front(); compared++;
    if (got !== exp) begin mismatched++; $display("FAIL en_hb_b: got %0d expected %0d", got, exp); end
    got = int'(bus.busy); exp = exp_q.pop_front(); compared++;
    if (got !== exp) begin mismatched++; $display("FAIL en_busy: got %0d expected %0d", got, exp); end
    got = int'(bus.fault); exp = exp_q.pop_front(); compared++;
    if (got !== exp) begin mismatched++; $display("FAIL en_fault_kept: got %0d expected %0d", got, exp); end
    measure(1'b1, 64, hf, hr);
    got = hf + hr; exp = exp_q.pop_front(); compared++;
    if (got !== exp) begin mismatched++; $display("FAIL en_b_quiet: got %0d expected %0d", got, exp); end
    bus.enable = 1'b1;
    wait_run(1'b0, 1500, blen, fnz, ok);
    got = int'(ok); exp = exp_q.pop_front(); compared++;
    if (got !== exp) begin mismatched++; $display("FAIL en_rerun: got %0d expected %0d", got, exp); end
    got = int'((fnz - 1) >= 16); exp = exp_q.pop_front(); compared++;
    if (got !== exp) begin mismatched++; $display("FAIL en_redead: got %0d zero cycles, need >=16", fnz - 1); end
  endtask

  task automatic test_duty_edges();
    int got, exp, blen, fnz, hf, hr;
    bit ok;
    bus.duty_max = 8'd0;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1);
    exp_q.push_back(255); exp_q.push_back(128); exp_q.push_back(32);
    repeat (2) @(negedge clk);
    measure(1'b0, 256, hf, hr);
    got = hf + hr; exp = exp_q.pop_front(); compared++;
    if (got !== exp) begin mismatched++; $display("FAIL duty0_legs: got %0d expected %0d", got, exp); end
    got = int'(bus.busy); exp = exp_q.pop_front(); compared++;
    if (got !== exp) begin mismatched++; $display("FAIL duty0_busy: got %0d expected %0d", got, exp); end
    bus.duty_max = 8'd255;
    wait_run(1'b0, 3000, blen, fnz, ok);
    got = int'(ok); exp = exp_q.pop_front(); compared++;
    if (got !== exp) begin mismatched++; $display("FAIL duty255_run: got %0d expected %0d", got, exp); end
    measure(1'b0, 256, hf, hr);
    exp = exp_q.pop_front(); compared++;
    if (hr !== exp) begin mismatched++; $display("FAIL duty255_high: got %0d expected %0d", hr, exp); end
    bus.duty_max = 8'd128;
    @(negedge clk);
    measure(1'b0, 256, hf, hr);
    exp = exp_q.pop_front(); compared++;
    if (hr !== exp) begin mismatched++; $display("FAIL duty128_high: got %0d expected %0d", hr, exp); end
    bus.duty_max = 8'd32;
    @(negedge clk);
    measure(1'b0, 256, hf, hr);
    exp = exp_q.pop_front(); compared++;
    if (hr !== exp) begin mismatched++; $display("FAIL duty32_high: got %0d expected %0d", hr, exp); end
  endtask

  task automatic test_reset_mid();
    int got, exp;
    exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(0); exp_q.push_back(0);
    for (int c = 0; c < 300 && bus.hb_a != 2'b01; c++) @(negedge clk);
    got = int'(bus.hb_a == 2'b01); exp = exp_q.pop_front(); compared++;
    if (got !== exp) begin mismatched++; $display("FAIL rst_mid_active: got %0d expected %0d", got, exp); end
    #2 reset = 1'b1;
    #1;
    got = int'(bus.hb_a); exp = exp_q.pop_front(); compared++;
    if (got !== exp) begin mismatched++; $display("FAIL rst_mid_hb_a: got %0d expected %0d", got, exp); end
    got = int'(bus.hb_b); exp = exp_q.pop_front(); compared++;
    if (got !== exp) begin mismatched++; $display("FAIL rst_mid_hb_b: got %0d expected %0d", got, exp); end
    bus.cmd_a = 2'b00; bus.cmd_b = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    got = int'(bus.fault); exp = exp_q.pop_front(); compared++;
    if (got !== exp) begin mismatched++; $display("FAIL rst_mid_fault: got %0d expected %0d", got, exp); end
    got = int'(bus.busy); exp = exp_q.pop_front(); compared++;
    if (got !== exp) begin mismatched++; $display("FAIL rst_mid_busy: got %0d expected %0d", got, exp); end
  endtask

  task automatic test_no_shoot_through();
    int got, exp;
    exp_q.push_back(0);
    got = int'(shoot_seen); exp = exp_q.pop_front(); compared++;
    if (got !== exp) begin mismatched++; $display("FAIL shoot_through: got %0d expected %0d", got, exp); end
  endtask

  initial begin
    reset = 1'b1;
    bus.enable = 1'b0; bus.cmd_a = 2'b00; bus.cmd_b = 2'b00; bus.duty_max = 8'd0;
    repeat (3) @(negedge clk);
    test_reset();
    test_start();
    test_reversal();
    test_illegal();
    test_enable_drop();
    test_duty_edges();
    test_reset_mid();
    test_no_shoot_through();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
